forwarding_hazard_unit: RTL and testbench

//  Produces the forwarding selects, forwarded operands and pipeline stalls for the 5-stage RV32IMA core.

---
 rtl/fwd_pkg.sv | 35 +++
 rtl/fwd_select.sv | 33 +++
 rtl/forwarding_hazard_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_forwarding_hazard_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
package fwd_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned OPC_W      = 7;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    FWD_REGF = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hazard_state_t;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  // Instructions that resolve their condition / target in ID.
  function automatic logic is_id_resolved(input logic [OPC_W-1:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JALR);
  endfunction

  // Instructions whose rs1 field is not a real source operand.
  function automatic logic has_no_rs1(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Source-register match against MEM/WB destinations; MEM wins, x0 never forwards.
module fwd_select
  import fwd_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] rs_address,
  input  logic              suppress,
  input  logic [ADDR_W-1:0] rd_address_mem,
  input  logic              reg_write_mem,
  input  logic [ADDR_W-1:0] rd_address_wb,
  input  logic              reg_write_wb,
  output fwd_sel_t          sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = reg_write_mem && (rd_address_mem != '0) && (rd_address_mem == rs_address);
  assign wb_hit  = reg_write_wb  && (rd_address_wb  != '0) && (rd_address_wb  == rs_address);

  always_comb begin
    sel = FWD_REGF;
    if (!suppress) begin
      if (mem_hit) begin
        sel = FWD_MEM;
      end else if (wb_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding for EX and ID-stage branch compare, plus load-use /
// branch-dependency stall generation for the 5-stage core.
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_address_id_i,
  input  logic [ADDR_W-1:0] rs2_address_id_i,
  input  logic [ADDR_W-1:0] rd_address_id_i,
  input  logic [OPC_W-1:0]  opcode_id_i,
  input  logic              reg_write_id_i,
  input  logic              mem_read_id_i,
  input  logic              id_ex_flush_i,
  input  logic [ADDR_W-1:0] rd_address_mem_i,
  input  logic              reg_write_mem_i,
  input  logic              mem_read_mem_i,
  input  logic [ADDR_W-1:0] rd_address_wb_i,
  input  logic              reg_write_wb_i,
  input  logic [DATA_W-1:0] rs1_data_id_i,
  input  logic [DATA_W-1:0] rs2_data_id_i,
  input  logic [DATA_W-1:0] rs1_data_ex_i,
  input  logic [DATA_W-1:0] rs2_data_ex_i,
  input  logic [DATA_W-1:0] alu_result_mem_i,
  input  logic [DATA_W-1:0] rd_data_wb_i,
  output logic [1:0]        alu_fwd_a_o,
  output logic [1:0]        alu_fwd_b_o,
  output logic [DATA_W-1:0] alu_in_a_o,
  output logic [DATA_W-1:0] alu_in_b_o,
  output logic [DATA_W-1:0] branch_condition_a_o,
  output logic [DATA_W-1:0] branch_condition_b_o,
  output logic              stall_o
);

  // ID/EX shadow of the fields the forwarding and hazard logic needs.
  logic [ADDR_W-1:0] rs1_ex_r;
  logic [ADDR_W-1:0] rs2_ex_r;
  logic [ADDR_W-1:0] rd_ex_r;
  logic              rw_ex_r;
  logic              ld_ex_r;
  logic              noa_ex_r;

  hazard_state_t     state_r;
  hazard_state_t     state_nxt;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt;

  fwd_sel_t          sel_alu_a;
  fwd_sel_t          sel_alu_b;
  fwd_sel_t          sel_br_a;
  fwd_sel_t          sel_br_b;

  logic              br_id;
  logic              ex_hit;
  logic              mem_hit;
  logic              load_use;
  logic              br_alu;
  logic              br_ld_ex;
  logic              br_ld_mem;
  logic [CNT_W-1:0]  need;

  assign br_id = is_id_resolved(opcode_id_i);

  fwd_select #(.ADDR_W(ADDR_W)) u_sel_alu_a (
    .rs_address     (rs1_ex_r),
    .suppress       (noa_ex_r),
    .rd_address_mem (rd_address_mem_i),
    .reg_write_mem  (reg_write_mem_i),
    .rd_address_wb  (rd_address_wb_i),
    .reg_write_wb   (reg_write_wb_i),
    .sel            (sel_alu_a)
  );

  fwd_select #(.ADDR_W(ADDR_W)) u_sel_alu_b (
    .rs_address     (rs2_ex_r),
    .suppress       (1'b0),
    .rd_address_mem (rd_address_mem_i),
    .reg_write_mem  (reg_write_mem_i),
    .rd_address_wb  (rd_address_wb_i),
    .reg_write_wb   (reg_write_wb_i),
    .sel            (sel_alu_b)
  );

  fwd_select #(.ADDR_W(ADDR_W)) u_sel_br_a (
    .rs_address     (rs1_address_id_i),
    .suppress       (!br_id),
    .rd_address_mem (rd_address_mem_i),
    .reg_write_mem  (reg_write_mem_i),
    .rd_address_wb  (rd_address_wb_i),
    .reg_write_wb   (reg_write_wb_i),
    .sel            (sel_br_a)
  );

  fwd_select #(.ADDR_W(ADDR_W)) u_sel_br_b (
    .rs_address     (rs2_address_id_i),
    .suppress       (!br_id),
    .rd_address_mem (rd_address_mem_i),
    .reg_write_mem  (reg_write_mem_i),
    .rd_address_wb  (rd_address_wb_i),
    .reg_write_wb   (reg_write_wb_i),
    .sel            (sel_br_b)
  );

  assign alu_fwd_a_o = sel_alu_a;
  assign alu_fwd_b_o = sel_alu_b;

  // Operand muxes follow the selects in the same cycle.
  always_comb begin
    alu_in_a_o           = rs1_data_ex_i;
    alu_in_b_o           = rs2_data_ex_i;
    branch_condition_a_o = rs1_data_id_i;
    branch_condition_b_o = rs2_data_id_i;
    case (sel_alu_a)
      FWD_MEM: alu_in_a_o = alu_result_mem_i;
      FWD_WB:  alu_in_a_o = rd_data_wb_i;
      default: alu_in_a_o = rs1_data_ex_i;
    endcase
    case (sel_alu_b)
      FWD_MEM: alu_in_b_o = alu_result_mem_i;
      FWD_WB:  alu_in_b_o = rd_data_wb_i;
      default: alu_in_b_o = rs2_data_ex_i;
    endcase
    case (sel_br_a)
      FWD_MEM: branch_condition_a_o = alu_result_mem_i;
      FWD_WB:  branch_condition_a_o = rd_data_wb_i;
      default: branch_condition_a_o = rs1_data_id_i;
    endcase
    case (sel_br_b)
      FWD_MEM: branch_condition_b_o = alu_result_mem_i;
      FWD_WB:  branch_condition_b_o = rd_data_wb_i;
      default: branch_condition_b_o = rs2_data_id_i;
    endcase
  end

  // Dependency of the ID instruction on the producer in EX or MEM.
  assign ex_hit  = (rd_ex_r != '0) &&
                   ((rd_ex_r == rs1_address_id_i) || (rd_ex_r == rs2_address_id_i));
  assign mem_hit = (rd_address_mem_i != '0) &&
                   ((rd_address_mem_i == rs1_address_id_i) || (rd_address_mem_i == rs2_address_id_i));

  assign load_use  = ld_ex_r && ex_hit;
  assign br_alu    = br_id && rw_ex_r && ex_hit;
  assign br_ld_ex  = br_id && ld_ex_r && ex_hit;
  assign br_ld_mem = br_id && mem_read_mem_i && mem_hit;

  // Largest stall requirement wins when several hazards coincide.
  always_comb begin
    need = '0;
    if (br_ld_ex) begin
      need = CNT_W'(2);
    end else if (load_use || br_alu || br_ld_mem) begin
      need = CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    stall_o   = 1'b0;
    if (id_ex_flush_i) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state_r)
        RUN: begin
          if (need != '0) begin
            stall_o = 1'b1;
          end
          if (need == CNT_W'(2)) begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_W'(1);
          end
        end
        HOLD: begin
          stall_o = 1'b1;
          cnt_nxt = CNT_W'(cnt_r - CNT_W'(1));
          if (cnt_r <= CNT_W'(1)) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Stalled or flushed cycles push a bubble into EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_ex_r <= '0;
      rs2_ex_r <= '0;
      rd_ex_r  <= '0;
      rw_ex_r  <= 1'b0;
      ld_ex_r  <= 1'b0;
      noa_ex_r <= 1'b0;
    end else if (stall_o || id_ex_flush_i) begin
      rs1_ex_r <= '0;
      rs2_ex_r <= '0;
      rd_ex_r  <= '0;
      rw_ex_r  <= 1'b0;
      ld_ex_r  <= 1'b0;
      noa_ex_r <= 1'b0;
    end else begin
      rs1_ex_r <= rs1_address_id_i;
      rs2_ex_r <= rs2_address_id_i;
      rd_ex_r  <= rd_address_id_i;
      rw_ex_r  <= reg_write_id_i;
      ld_ex_r  <= mem_read_id_i;
      noa_ex_r <= has_no_rs1(opcode_id_i);
    end
  end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed checks of forwarding selects, forwarded data and stall sequencing.
module tb_forwarding_hazard_unit;
  import fwd_pkg::*;

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_NOP  = 7'b0010011;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1_address_id_i, rs2_address_id_i, rd_address_id_i;
  logic [6:0]  opcode_id_i;
  logic        reg_write_id_i, mem_read_id_i, id_ex_flush_i;
  logic [4:0]  rd_address_mem_i;
  logic        reg_write_mem_i, mem_read_mem_i;
  logic [4:0]  rd_address_wb_i;
  logic        reg_write_wb_i;
  logic [31:0] rs1_data_id_i, rs2_data_id_i, rs1_data_ex_i, rs2_data_ex_i;
  logic [31:0] alu_result_mem_i, rd_data_wb_i;
  logic [1:0]  alu_fwd_a_o, alu_fwd_b_o;
  logic [31:0] alu_in_a_o, alu_in_b_o, branch_condition_a_o, branch_condition_b_o;
  logic        stall_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  forwarding_hazard_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .rs1_address_id_i     (rs1_address_id_i),
    .rs2_address_id_i     (rs2_address_id_i),
    .rd_address_id_i      (rd_address_id_i),
    .opcode_id_i          (opcode_id_i),
    .reg_write_id_i       (reg_write_id_i),
    .mem_read_id_i        (mem_read_id_i),
    .id_ex_flush_i        (id_ex_flush_i),
    .rd_address_mem_i     (rd_address_mem_i),
    .reg_write_mem_i      (reg_write_mem_i),
    .mem_read_mem_i       (mem_read_mem_i),
    .rd_address_wb_i      (rd_address_wb_i),
    .reg_write_wb_i       (reg_write_wb_i),
    .rs1_data_id_i        (rs1_data_id_i),
    .rs2_data_id_i        (rs2_data_id_i),
    .rs1_data_ex_i        (rs1_data_ex_i),
    .rs2_data_ex_i        (rs2_data_ex_i),
    .alu_result_mem_i     (alu_result_mem_i),
    .rd_data_wb_i         (rd_data_wb_i),
    .alu_fwd_a_o          (alu_fwd_a_o),
    .alu_fwd_b_o          (alu_fwd_b_o),
    .alu_in_a_o           (alu_in_a_o),
    .alu_in_b_o           (alu_in_b_o),
    .branch_condition_a_o (branch_condition_a_o),
    .branch_condition_b_o (branch_condition_b_o),
    .stall_o              (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [6:0] opc, input logic rw, input logic mr);
    rs1_address_id_i = rs1;
    rs2_address_id_i = rs2;
    rd_address_id_i  = rd;
    opcode_id_i      = opc;
    reg_write_id_i   = rw;
    mem_read_id_i    = mr;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic rw, input logic mr, input logic [31:0] d);
    rd_address_mem_i = rd;
    reg_write_mem_i  = rw;
    mem_read_mem_i   = mr;
    alu_result_mem_i = d;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic rw, input logic [31:0] d);
    rd_address_wb_i = rd;
    reg_write_wb_i  = rw;
    rd_data_wb_i    = d;
  endtask

  task automatic clear_pipe();
    set_id(5'd0, 5'd0, 5'd0, OPC_NOP, 1'b0, 1'b0);
    set_mem(5'd0, 1'b0, 1'b0, 32'h0);
    set_wb(5'd0, 1'b0, 32'h0);
    id_ex_flush_i = 1'b0;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    clear_pipe();
    rs1_data_ex_i = 32'h1111_0001;
    rs2_data_ex_i = 32'h2222_0002;
    rs1_data_id_i = 32'h3333_0003;
    rs2_data_id_i = 32'h4444_0004;
    #1 reset = 1'b0;
    #11;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_fwd_a", 32'(alu_fwd_a_o), 32'd0);
    check("rst_fwd_b", 32'(alu_fwd_b_o), 32'd0);
    check("rst_in_a", alu_in_a_o, 32'h1111_0001);
    check("rst_in_b", alu_in_b_o, 32'h2222_0002);
    check("rst_br_a", branch_condition_a_o, 32'h3333_0003);
    @(negedge clk);
    reset = 1'b1;

    // add x6,x5,x5 in EX, producer of x5 in MEM
    set_id(5'd5, 5'd5, 5'd6, OPC_OP, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd0, OPC_NOP, 1'b0, 1'b0);
    set_mem(5'd5, 1'b1, 1'b0, 32'hDEAD_BEEF);
    #1;
    check("mem_fwd_a", 32'(alu_fwd_a_o), 32'(2'b10));
    check("mem_fwd_b", 32'(alu_fwd_b_o), 32'(2'b10));
    check("mem_in_a", alu_in_a_o, 32'hDEAD_BEEF);
    check("mem_in_b", alu_in_b_o, 32'hDEAD_BEEF);
    check("mem_nostall", 32'(stall_o), 32'd0);

    // x7 live in both MEM and WB
    clear_pipe();
    set_id(5'd7, 5'd7, 5'd12, OPC_OP, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd0, OPC_NOP, 1'b0, 1'b0);
    set_mem(5'd7, 1'b1, 1'b0, 32'h1);
    set_wb(5'd7, 1'b1, 32'h2);
    #1;
    check("prio_fwd_a", 32'(alu_fwd_a_o), 32'(2'b10));
    check("prio_in_a", alu_in_a_o, 32'h1);
    set_mem(5'd0, 1'b1, 1'b0, 32'h1);
    #1;
    check("wb_fwd_b", 32'(alu_fwd_b_o), 32'(2'b01));
    check("wb_in_b", alu_in_b_o, 32'h2);
    set_wb(5'd7, 1'b0, 32'h2);
    #1;
    check("x0_fwd_a", 32'(alu_fwd_a_o), 32'(2'b00));
    check("x0_in_a", alu_in_a_o, 32'h1111_0001);

    // lw x8 in EX, add x9,x8,x1 in ID
    clear_pipe();
    set_id(5'd1, 5'd0, 5'd8, OPC_LOAD, 1'b1, 1'b1);
    tick();
    set_id(5'd8, 5'd1, 5'd9, OPC_OP, 1'b1, 1'b0);
    #1;
    check("lu_stall1", 32'(stall_o), 32'd1);
    tick();
    set_mem(5'd8, 1'b1, 1'b1, 32'h0);
    #1;
    check("lu_stall_end", 32'(stall_o), 32'd0);
    tick();
    set_id(5'd0, 5'd0, 5'd0, OPC_NOP, 1'b0, 1'b0);
    set_mem(5'd0, 1'b0, 1'b0, 32'h0);
    set_wb(5'd8, 1'b1, 32'hCAFE_F00D);
    #1;
    check("lu_nostall", 32'(stall_o), 32'd0);
    check("lu_fwd_a", 32'(alu_fwd_a_o), 32'(2'b01));
    check("lu_in_a", alu_in_a_o, 32'hCAFE_F00D);

    // lw x10 in EX, beq x10,x0 in ID
    clear_pipe();
    set_id(5'd0, 5'd0, 5'd10, OPC_LOAD, 1'b1, 1'b1);
    tick();
    set_id(5'd10, 5'd0, 5'd0, OPC_BRANCH, 1'b0, 1'b0);
    #1;
    check("bl_stall1", 32'(stall_o), 32'd1);
    tick();
    set_mem(5'd10, 1'b1, 1'b1, 32'h0);
    #1;
    check("bl_stall2", 32'(stall_o), 32'd1);
    tick();
    set_mem(5'd0, 1'b0, 1'b0, 32'h0);
    set_wb(5'd10, 1'b1, 32'hBEEF_0010);
    #1;
    check("bl_release", 32'(stall_o), 32'd0);
    check("bl_br_a", branch_condition_a_o, 32'hBEEF_0010);
    check("bl_br_b", branch_condition_b_o, 32'h4444_0004);

    // add x13 in EX, jalr using x13 in ID
    clear_pipe();
    set_id(5'd0, 5'd0, 5'd13, OPC_OP, 1'b1, 1'b0);
    tick();
    set_id(5'd13, 5'd0, 5'd1, OPC_JALR, 1'b1, 1'b0);
    #1;
    check("ba_stall", 32'(stall_o), 32'd1);
    tick();
    set_mem(5'd13, 1'b1, 1'b0, 32'h55);
    #1;
    check("ba_release", 32'(stall_o), 32'd0);
    check("ba_br_a", branch_condition_a_o, 32'h55);

    // lui x11 in MEM, auipc with rs1/rs2 fields = x11 in EX
    clear_pipe();
    set_id(5'd11, 5'd11, 5'd14, OPC_AUIPC, 1'b1, 1'b0);
    tick();
    set_id(5'd0, 5'd0, 5'd0, OPC_NOP, 1'b0, 1'b0);
    set_mem(5'd11, 1'b1, 1'b0, 32'h77);
    #1;
    check("noa_fwd_a", 32'(alu_fwd_a_o), 32'(2'b00));
    check("noa_in_a", alu_in_a_o, 32'h1111_0001);
    check("noa_fwd_b", 32'(alu_fwd_b_o), 32'(2'b10));

    // flush while in HOLD
    clear_pipe();
    set_id(5'd0, 5'd0, 5'd10, OPC_LOAD, 1'b1, 1'b1);
    tick();
    set_id(5'd10, 5'd0, 5'd0, OPC_BRANCH, 1'b0, 1'b0);
    tick();
    check("fl_hold", 32'(stall_o), 32'd1);
    id_ex_flush_i = 1'b1;
    #1;
    check("fl_wins", 32'(stall_o), 32'd0);
    tick();
    id_ex_flush_i = 1'b0;
    #1;
    check("fl_run", 32'(stall_o), 32'd0);

    // async reset while in HOLD
    clear_pipe();
    set_id(5'd0, 5'd0, 5'd10, OPC_LOAD, 1'b1, 1'b1);
    tick();
    set_id(5'd10, 5'd0, 5'd0, OPC_BRANCH, 1'b0, 1'b0);
    tick();
    check("rh_hold", 32'(stall_o), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rh_stall", 32'(stall_o), 32'd0);
    check("rh_fwd_a", 32'(alu_fwd_a_o), 32'd0);
    check("rh_fwd_b", 32'(alu_fwd_b_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rh_after", 32'(stall_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
